// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display bus: segment bit
// positions, the blank pattern and the hex-digit glyph table. The display
// encoder uses the same table, so encoder and read-back path cannot drift apart.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    // Bit positions within the 8-bit segment bus {a,b,c,d,e,f,g,dp}
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-low glyphs over seg[7:1] = {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_PAT_0 = 7'b0000001;
    localparam logic [6:0] SEG_PAT_1 = 7'b1001111;
    localparam logic [6:0] SEG_PAT_2 = 7'b0010010;
    localparam logic [6:0] SEG_PAT_3 = 7'b0000110;
    localparam logic [6:0] SEG_PAT_4 = 7'b1001100;
    localparam logic [6:0] SEG_PAT_5 = 7'b0100100;
    localparam logic [6:0] SEG_PAT_6 = 7'b0100000;
    localparam logic [6:0] SEG_PAT_7 = 7'b0001111;
    localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9 = 7'b0001100;
    localparam logic [6:0] SEG_PAT_A = 7'b0001000;
    localparam logic [6:0] SEG_PAT_B = 7'b1100000;
    localparam logic [6:0] SEG_PAT_C = 7'b1110010;
    localparam logic [6:0] SEG_PAT_D = 7'b1000010;
    localparam logic [6:0] SEG_PAT_E = 7'b0110000;
    localparam logic [6:0] SEG_PAT_F = 7'b0111000;

    // Indexed by nibble value so the decoder can loop over it
    localparam logic [6:0] SEG_DIGITS [16] = '{
        SEG_PAT_0, SEG_PAT_1, SEG_PAT_2, SEG_PAT_3,
        SEG_PAT_4, SEG_PAT_5, SEG_PAT_6, SEG_PAT_7,
        SEG_PAT_8, SEG_PAT_9, SEG_PAT_A, SEG_PAT_B,
        SEG_PAT_C, SEG_PAT_D, SEG_PAT_E, SEG_PAT_F
    };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex-digit glyph table: maps seg[7:1] back to a
// nibble and flags whether the glyph is a legal digit or an all-off blank.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       legal_o,
    output logic       blank_o
);

    // Table lookup; nibble stays 0 for blank and unknown glyphs
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        nibble_o = 4'd0;
        legal_o  = 1'b0;
        blank_o  = (seg_i == SEG_BLANK);
        for (int d = 0; d < 16; d++) begin
            if (seg_i == SEG_DIGITS[d]) begin
                nibble_o = 4'(d);
                legal_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Read-back monitor for the multiplexed 7-segment bus. Each {an,seg} pair must
// be seen on STABLE_CYCLES consecutive edges before it is captured, which
// rejects the short glitches that occur while the driver switches digits.
// Captured digits are decoded back to nibbles and reassembled into a 32-bit
// value; frame_done marks the point where every digit position has been seen.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4   // legal range 2..255
)
(
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic [7:0]  an,
    input  logic [7:0]  seg,
    output logic [31:0] value,
    output logic [7:0]  digit_valid,
    output logic [7:0]  dp_mask,
    output logic        frame_done,
    output logic        bad_pattern,
    output logic        an_conflict
);

    localparam logic [7:0] CNT_SAT    = 8'(STABLE_CYCLES);
    localparam logic [7:0] CAPTURE_AT = 8'(STABLE_CYCLES - 1);

    // Filter state
    logic [15:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  seen_q, seen_d;

    // Output registers
    logic [31:0] value_q, value_d;
    logic [7:0]  valid_q, valid_d;
    logic [7:0]  dp_q, dp_d;
    logic        frame_q, frame_d;
    logic        bad_q, bad_d;
    logic        conflict_q, conflict_d;

    logic [15:0] sample;
    logic        same;
    logic        capture;
    logic [7:0]  an_sel;
    logic        any_sel;
    logic        multi_sel;
    logic [7:0]  seen_upd;

    logic [3:0]  dec_nibble;
    logic        dec_legal;
    logic        dec_blank;

    seg_pattern_decode u_decode (
        .seg_i    (seg[SEG_A:SEG_G]),
        .nibble_o (dec_nibble),
        .legal_o  (dec_legal),
        .blank_o  (dec_blank)
    );

    assign sample    = {an, seg};
    assign same      = (sample == prev_q);
    // Fires once per stable run: the count saturates past CAPTURE_AT
    assign capture   = same && (cnt_q == CAPTURE_AT);
    assign an_sel    = ~an;
    assign any_sel   = |an_sel;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi_sel = |(an_sel & (an_sel - 8'd1));
    assign seen_upd  = seen_q | an_sel;

    // Stability counter: restart at 1 on any change, saturate at STABLE_CYCLES
    always_comb begin
        if (!same)
            cnt_d = 8'd1;
        else if (cnt_q == CNT_SAT)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;
    end

    // Capture handling: field updates, frame bookkeeping and error pulses
    always_comb begin
        value_d    = value_q;
        valid_d    = valid_q;
        dp_d       = dp_q;
        seen_d     = seen_q;
        frame_d    = 1'b0;
        bad_d      = 1'b0;
        conflict_d = 1'b0;

        if (capture && any_sel) begin
            if (multi_sel) begin
                conflict_d = 1'b1;
            end else begin
                if (seen_upd == 8'hFF) begin
                    frame_d = 1'b1;
                    seen_d  = 8'h00;
                end else begin
                    seen_d  = seen_upd;
                end
                dp_d    = (dp_q & ~an_sel) | (an_sel & {8{~seg[SEG_DP]}});
                valid_d = (valid_q & ~an_sel) | (an_sel & {8{dec_legal}});
                bad_d   = !dec_legal && !dec_blank;
                // Decoder already returns 0 for blank and unknown glyphs
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_sel[i])
                        value_d[4*i +: 4] = dec_nibble;
                end
            end
        end
    end

    // State and output registers; prev resets to the blank bus value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= 16'hFFFF;
            cnt_q      <= 8'd0;
            seen_q     <= 8'd0;
            value_q    <= 32'd0;
            valid_q    <= 8'd0;
            dp_q       <= 8'd0;
            frame_q    <= 1'b0;
            bad_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            prev_q     <= sample;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
            bad_q      <= bad_d;
            conflict_q <= conflict_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign dp_mask     = dp_q;
    assign frame_done  = frame_q;
    assign bad_pattern = bad_q;
    assign an_conflict = conflict_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: reset, full frame, glitch filter,
// blank/bad glyphs, an conflict and asynchronous reset mid-frame.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an  = 8'hFF;
    logic [7:0]  seg = 8'hFF;
    logic [31:0] value;
    logic [7:0]  digit_valid;
    logic [7:0]  dp_mask;
    logic        frame_done;
    logic        bad_pattern;
    logic        an_conflict;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters and edge bookkeeping
    int cyc      = 0;
    int fd_cnt   = 0;
    int bad_cnt  = 0;
    int conf_cnt = 0;
    int fd_cyc   = -1;
    int start_cyc;
    int fd_before;

    // Expected-state model
    logic [31:0] exp_value;
    logic [7:0]  exp_valid;
    logic [7:0]  exp_dp;
    logic [31:0] frame_val;

    // Active-low glyphs over seg[7:1], indexed by nibble
    logic [6:0] pat [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .value       (value),
        .digit_valid (digit_valid),
        .dp_mask     (dp_mask),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern),
        .an_conflict (an_conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count registered pulses shortly after each edge
    always @(posedge clk) begin
        #1;
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (bad_pattern) bad_cnt = bad_cnt + 1;
        if (an_conflict) conf_cnt = conf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply a pair at a falling edge and hold it for n sampling edges
    task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    // Show one legal digit long enough to be captured; update the model
    task automatic scan_digit(input int d, input logic [3:0] nib, input logic dp);
        logic [7:0] a;
        a = ~(8'd1 << d);
        start_cyc = cyc + 1;
        drive(a, {pat[nib], ~dp}, 6);
        exp_value[4*d +: 4] = nib;
        exp_valid[d]        = 1'b1;
        exp_dp[d]           = dp;
    endtask

    initial begin
        exp_value = 32'd0;
        exp_valid = 8'd0;
        exp_dp    = 8'd0;

        // Reset with no clock edge in between
        #1 rst = 1'b0;
        #1;
        check("rst_value", value, 32'd0);
        check("rst_valid", {24'd0, digit_valid}, 32'd0);
        check("rst_dp", {24'd0, dp_mask}, 32'd0);
        check("rst_pulses", {29'd0, frame_done, bad_pattern, an_conflict}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(8'hFF, 8'hFF, 20);
        check("idle_pulses", 32'(fd_cnt + bad_cnt + conf_cnt), 32'd0);
        check("idle_value", value, 32'd0);

        // Full frame 0x1234ABCD
        frame_val = 32'h1234ABCD;
        for (int d = 0; d < 8; d++)
            scan_digit(d, frame_val[4*d +: 4], 1'b0);
        check("frame_value", value, 32'h1234ABCD);
        check("frame_valid", {24'd0, digit_valid}, 32'h000000FF);
        check("frame_dp", {24'd0, dp_mask}, 32'd0);
        check("frame_done_cnt", 32'(fd_cnt), 32'd1);
        check("frame_done_edge", 32'(fd_cyc), 32'(start_cyc + 3));

        // Glitch filter: three samples are not enough, four are
        drive(8'hFE, {pat[5], 1'b1}, 3);
        drive(8'hFF, 8'hFF, 2);
        check("glitch_no_capture", value, exp_value);
        drive(8'hFE, {pat[5], 1'b1}, 4);
        exp_value[3:0] = 4'h5;
        check("glitch_capture_4", value, exp_value);

        // Unknown glyph on digit 2
        drive(8'hFB, {7'b1011011, 1'b1}, 4);
        exp_value[11:8] = 4'h0;
        exp_valid[2]    = 1'b0;
        check("bad_pulse", 32'(bad_cnt), 32'd1);
        check("bad_valid", {24'd0, digit_valid}, {24'd0, exp_valid});
        check("bad_value", value, exp_value);
        // Blank glyph: cleared nibble, no error
        drive(8'hFB, 8'hFF, 4);
        check("blank_no_pulse", 32'(bad_cnt), 32'd1);
        check("blank_value", value, exp_value);
        check("blank_valid", {24'd0, digit_valid}, {24'd0, exp_valid});
        // Digit 0 glyph with decimal point lit
        drive(8'hFB, 8'b0000001_0, 4);
        exp_valid[2] = 1'b1;
        exp_dp[2]    = 1'b1;
        check("dp_mask", {24'd0, dp_mask}, {24'd0, exp_dp});
        check("dp_valid", {24'd0, digit_valid}, {24'd0, exp_valid});
        check("dp_value", value, exp_value);

        // Two digits enabled at once: pulse only, no field or seen update
        drive(8'hF3, {pat[8], 1'b1}, 4);
        check("conflict_pulse", 32'(conf_cnt), 32'd1);
        check("conflict_value", value, exp_value);
        // Digits 0 and 2 are already seen; digit 3 is held back last
        fd_before = fd_cnt;
        scan_digit(1, 4'h9, 1'b0);
        scan_digit(4, 4'hE, 1'b0);
        scan_digit(5, 4'hF, 1'b0);
        scan_digit(6, 4'h6, 1'b0);
        scan_digit(7, 4'h7, 1'b0);
        check("conflict_no_early_frame", 32'(fd_cnt), 32'(fd_before));
        scan_digit(3, 4'hA, 1'b0);
        check("conflict_frame_done", 32'(fd_cnt), 32'(fd_before + 1));
        check("conflict_frame_value", value, exp_value);
        check("conflict_frame_dp", {24'd0, dp_mask}, {24'd0, exp_dp});

        // Asynchronous reset between edges, mid-frame
        for (int d = 0; d < 4; d++)
            scan_digit(d, 4'(d + 1), 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midrst_value", value, 32'd0);
        check("midrst_valid", {24'd0, digit_valid}, 32'd0);
        check("midrst_dp", {24'd0, dp_mask}, 32'd0);
        #1 rst = 1'b1;
        exp_value = 32'd0;
        exp_valid = 8'd0;
        exp_dp    = 8'd0;
        @(negedge clk);
        fd_before = fd_cnt;
        for (int d = 4; d < 8; d++)
            scan_digit(d, 4'(d + 4), 1'b0);
        check("midrst_no_frame", 32'(fd_cnt), 32'(fd_before));
        for (int d = 0; d < 4; d++)
            scan_digit(d, 4'(d + 1), 1'b0);
        check("midrst_frame_done", 32'(fd_cnt), 32'(fd_before + 1));
        check("midrst_value_final", value, 32'hBA984321);
        check("midrst_valid_final", {24'd0, digit_valid}, 32'h000000FF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Monitor for the multiplexed 7-segment display bus: samples the active-low digit enables and active-low segment lines, filters scan glitches, inverts the hex-digit segment encoding back to nibbles and reassembles the displayed 32-bit value. It sits beside the on-board display driver as a read-back and self-check path, letting the board or testbench compare what the display shows against the debug value that was sent to it.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2..255.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- an  in  8  digit enables, active-low; bit i low selects digit i, where digit 0 is the least-significant nibble.
- seg  in  8  segments, active-low, ordered {a,b,c,d,e,f,g,dp}; seg[7]=a, seg[1]=g, seg[0]=dp.
- value  out  32  reassembled value; digit i occupies value[4i+3:4i].
- digit_valid  out  8  bit i set when the last capture of digit i was a legal hex pattern.
- dp_mask  out  8  bit i = decimal point lit (~seg[0]) at the last capture of digit i.
- frame_done  out  1  one-cycle pulse when all 8 digit positions have been captured since the previous pulse.
- bad_pattern  out  1  one-cycle pulse on capture of an unknown, non-blank seg[7:1].
- an_conflict  out  1  one-cycle pulse on capture with more than one an bit low.

## Operation
- Registers: prev (16 bits, last {an,seg}), cnt (8 bits, saturating at STABLE_CYCLES), seen (8 bits).
- Each edge: if {an,seg}==prev then cnt<=min(cnt+1,STABLE_CYCLES), else cnt<=1. prev<={an,seg}.
- Capture is asserted when {an,seg}==prev and cnt==STABLE_CYCLES-1, i.e. on the STABLE_CYCLES-th consecutive identical sample. It fires only once per stable run. A digit that reappears after any other input value is captured again.
- On capture:
  - an==8'hFF: ignored. No update, no pulse.
  - More than one an bit low: an_conflict pulse. No field update, seen unchanged.
  - Exactly one bit i low: seen[i]<=1 and dp_mask[i]<=~seg[0]. seg[7:1] is then decoded:
    - Legal pattern: value nibble i<=code and digit_valid[i]<=1.
    - Blank (1111111): nibble i<=0 and digit_valid[i]<=0. No error.
    - Anything else: nibble i<=0, digit_valid[i]<=0, bad_pattern pulse.
- Decode table, seg[7:1] to nibble:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0001100=9, 0001000=A, 1100000=b
  - 1110010=c, 1000010=d, 0110000=E, 0111000=F
- Frame completion: if the capture makes seen==8'hFF, frame_done pulses on that edge and seen<=0, not to the captured bit. A repeated capture of an already-seen digit updates its fields and leaves seen unchanged.

## Timing
- Capture latency: outputs update on the STABLE_CYCLES-th rising edge that samples the same {an,seg}. With the default of 4, a pair first sampled at edge k is reflected at edge k+3.
- A pair held for fewer than STABLE_CYCLES sampling edges produces no capture and no pulse.
- All pulses are exactly one cycle wide, registered, and aligned with the field update.
- Reset values:
  - value=0, digit_valid=0, dp_mask=0, seen=0, cnt=0
  - frame_done=0, bad_pattern=0, an_conflict=0
  - prev=16'hFFFF (blank)
- Reset asserts asynchronously mid-frame and clears everything with no clock edge. After release, the first stable run is captured normally.

## Structure
- Package seg_pkg holds:
  - segment index constants (SEG_A..SEG_G, SEG_DP)
  - SEG_BLANK=7'b1111111
  - the 16 digit pattern constants, shared with the display encoder
  - NUM_DIGITS=8
- Sub-module seg_pattern_decode is purely combinational. Input seg[7:1]; outputs nibble[3:0], legal, blank.
- The top module holds prev, cnt, seen, the an one-hot check, and the output registers.

## Test plan
- Reset: drive rst low with no clock → all outputs 0. Release and hold an=FF for 20 cycles → no pulses.
- Full frame: scan digits 0..7 with patterns for 0x1234ABCD, each held 6 cycles → value=32'h1234ABCD, digit_valid=FF, dp_mask=00, and a single frame_done on the 4th sample edge of digit 7.
- Glitch filter: hold an=FE, seg=pattern 5 for 3 cycles, then change → no capture. Hold it 4 cycles → nibble 0=5.
- Bad and blank: an=FB with seg[7:1]=1011011 → bad_pattern pulse, digit_valid[2]=0. Then seg=8'hFF → no pulse, nibble 2=0. Then seg=8'b00000010 (pattern 0 with dp lit) → dp_mask[2]=1, digit_valid[2]=1.
- Conflict: an=F3 held 4 cycles → an_conflict pulse, value and seen unchanged. Then finish the frame → frame_done fires only after all 8 positions are captured.
- Reset mid-frame: capture digits 0..3, then pulse rst low between edges → outputs clear immediately. Scan digits 4..7 → no frame_done until digits 0..3 are recaptured.
